io_output_buffer: RTL
=====================

Name: io_output_buffer

Overview:
- Output-port stage directly downstream of StagedDatapath.
- Captures every value the datapath writes to its 16-bit OUT port (qualified by a write strobe) into a small FIFO.
- Drains the FIFO to a consumer (display/UART/bench) over a valid/ready interface.
- Gives backpressure (dp_stall) to the datapath and flags dropped writes.

Parameters:
- WIDTH, 16, data width; matches datapath OUT.
- DEPTH, 8, FIFO entries; must be a power of 2, minimum 2.
- ADDR_W, 3, log2(DEPTH); pointer width.

Ports:
- CLK  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- dp_out  in  WIDTH  datapath OUT value.
- dp_out_we  in  1  datapath asserts for one cycle per OUT write.
- dp_stall  out  1  FIFO full; the datapath must hold its OUT write.
- m_data  out  WIDTH  head-of-FIFO data.
- m_valid  out  1  m_data is valid.
- m_ready  in  1  consumer accepts m_data this cycle.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was dropped.
- clear_ovf  in  1  synchronous clear of overflow.

Behaviour:
- Reset (reset=0, asynchronous):
  - Pointers and count go to 0; m_valid=0, m_data=0, overflow=0, dp_stall=0.
  - Storage contents are don't-care.
  - Reset asserted mid-operation discards all queued data immediately.
- Push:
  - Occurs when dp_out_we=1 and (count<DEPTH, or pop in the same cycle).
  - dp_out is written at the write pointer; the pointer increments modulo DEPTH (natural wrap).
- Pop:
  - Occurs when m_valid=1 and m_ready=1.
  - The read pointer increments modulo DEPTH.
- Count:
  - push only: +1.
  - pop only: -1.
  - both: unchanged.
  - Never exceeds DEPTH and never underflows.
- Full with simultaneous pop: a write while count==DEPTH is accepted if a pop occurs in the same cycle; count stays DEPTH.
- Full without pop: a write while count==DEPTH is dropped, and overflow is set on the next edge.
- Overflow flag:
  - clear_ovf=1 clears it on the next edge.
  - If a drop and clear_ovf occur in the same cycle, the drop wins and overflow stays 1.
- dp_stall:
  - Combinational, equal to (count==DEPTH).
  - It is not reduced by a same-cycle pop, so there is no combinational path from m_ready to dp_stall.
- Latency: a value pushed at edge N is visible on m_data/m_valid after edge N (one cycle), including when the FIFO was empty.
- Output registers: m_data and m_valid are registered from storage/pointers.
- Empty: m_valid=0. A push into an empty FIFO with m_ready=1 does not pop that same cycle.
- Handshake stability: while m_valid=1 and m_ready=0, m_data and m_valid hold stable.
  - m_valid never drops without a pop or a reset.
- Back-to-back streaming: with m_ready held 1 and one push per cycle, the block sustains one word per cycle.
- State (implicit, via count):
  - EMPTY (0) → PARTIAL on push.
  - PARTIAL → FULL at DEPTH.
  - FULL → PARTIAL on pop.
  - PARTIAL → EMPTY when the last entry is popped.

Optional Feature:
- Macro: IO_OUT_DEDUP_EN.
- When defined:
  - The block keeps a last_accepted register (reset 0) plus a "seen" bit (reset 0).
  - A dp_out_we whose dp_out equals last_accepted, while seen=1, is silently ignored: no push, no overflow, count unchanged.
  - seen is set on the first accepted push.
  - Dropped (overflow) writes do not update last_accepted.
- When not defined: every strobed write is pushed; no extra registers.

Test Plan:
- Reset then single write:
  - Stimulus: reset low for 10 cycles, then dp_out=16'hABCD with one-cycle dp_out_we, m_ready=0.
  - Response: m_valid=1 and m_data=ABCD one edge later; count=1; held stable over 5 idle cycles.
- Order and pop:
  - Stimulus: write ABCD, BEEF, DEAD on consecutive cycles, then m_ready=1.
  - Response: m_data sequence ABCD, BEEF, DEAD on three consecutive cycles; count returns to 0; m_valid=0.
- Fill and overflow:
  - Stimulus: 9 writes 16'h0001..16'h0009 with m_ready=0, DEPTH=8.
  - Response: dp_stall=1 after the 8th; 9th dropped; overflow=1; drain yields 0001..0008 only.
  - Follow-up: clear_ovf pulse makes overflow=0.
- Full plus simultaneous push/pop:
  - Stimulus: FIFO full, write 16'h1234 with m_ready=1.
  - Response: head popped; 1234 accepted; count stays 8; overflow stays 0.
- Wrap-around:
  - Stimulus: 20 words 16'h0100..16'h0113 streamed, m_ready toggling 1/0 every cycle.
  - Response: all 20 received in order, none lost, overflow=0.
- Reset mid-operation:
  - Stimulus: 4 entries queued, reset pulsed low asynchronously between edges.
  - Response: m_valid=0 and count=0 immediately; next write DEAD appears as the only entry.
  - With IO_OUT_DEDUP_EN: writing BEEF, BEEF, BEEF yields a single BEEF entry.

Source files
------------

// File: rtl/io_output_buffer.sv
// Output FIFO between the datapath OUT port and a valid/ready consumer, with stall and sticky overflow.
// Optional write de-duplication is enabled by defining IO_OUT_DEDUP_EN.
module io_output_buffer #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [WIDTH-1:0]  dp_out,
    input  logic              dp_out_we,
    output logic              dp_stall,
    output logic [WIDTH-1:0]  m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              clear_ovf
);

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_CNT  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ONE_PTR  = ADDR_W'(1);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_count;
    logic              r_valid;
    logic [WIDTH-1:0]  r_data;
    logic              r_overflow;

    logic              w_full;
    logic              w_pop;
    logic              w_dup;
    logic              w_write;
    logic              w_push;
    logic              w_drop;
    logic              w_bypass;
    logic [ADDR_W:0]   w_count_nxt;
    logic [ADDR_W-1:0] w_rptr_nxt;

`ifdef IO_OUT_DEDUP_EN
    logic [WIDTH-1:0]  r_last;
    logic              r_seen;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_last <= '0;
            r_seen <= 1'b0;
        end else if (w_push) begin
            r_last <= dp_out;
            r_seen <= 1'b1;
        end
    end

    assign w_dup = r_seen && (dp_out == r_last);
`else
    assign w_dup = 1'b0;
`endif

    always_comb begin
        w_full      = (r_count == FULL_CNT);
        w_pop       = r_valid & m_ready;
        w_write     = dp_out_we & ~w_dup;
        w_push      = w_write & (~w_full | w_pop);
        w_drop      = w_write & w_full & ~w_pop;
        w_rptr_nxt  = w_pop ? (r_rptr + ONE_PTR) : r_rptr;
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + ONE_CNT;
            2'b01:   w_count_nxt = r_count - ONE_CNT;
            default: w_count_nxt = r_count;
        endcase
        // New word becomes the head when nothing else remains after this cycle's pop.
        w_bypass = w_push && ((r_count == '0) || (r_count == ONE_CNT && w_pop));
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= dp_out;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_rptr  <= w_rptr_nxt;
            if (w_push) begin
                r_wptr <= r_wptr + ONE_PTR;
            end
            r_valid <= (w_count_nxt != '0);
            if (w_count_nxt != '0) begin
                r_data <= w_bypass ? dp_out : r_mem[w_rptr_nxt];
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign dp_stall = w_full;
    assign m_data   = r_data;
    assign m_valid  = r_valid;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule
